// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: FSM state encoding
// and the bit-offset helper used to unpack the flattened per-port buses.
package regfile_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux with busy gating, zero-entry gating
// and optional same-cycle forwarding of the write port.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [DATA_W-1:0] i_mem [2**ADDR_W],
  input  logic              i_state,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (ZERO_REG != 0) && (i_addr == '0);
  assign w_hit     = (BYPASS != 0) && i_wr_en && (i_addr == i_wr_addr);

  // Priority: sweep blanks everything, then the hardwired zero, then forwarding.
  always_comb begin
    o_data = i_mem[i_addr];
    if (i_state == ST_CLEAR) begin
      o_data = '0;
    end else if (w_is_zero) begin
      o_data = '0;
    end else if (w_hit) begin
      o_data = i_wr_data;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file with N combinational read ports, one write port
// and a sequential clear sweep (one entry per cycle) after reset or on request.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_in,
  input  logic                     wr_en_in,
  input  logic [ADDR_W-1:0]        wr_addr_in,
  input  logic [DATA_W-1:0]        wr_data_in,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_in,
  output logic [NUM_RD*DATA_W-1:0] rd_data_out,
  output logic                     ready_out,
  output logic                     busy_out
);

  localparam int DEPTH = 2**ADDR_W;

  logic              r_state;
  logic              w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_busy;
  logic              w_wr_accept;

  assign w_busy      = (r_state == ST_CLEAR);
  assign ready_out   = ~w_busy;
  assign busy_out    = w_busy;
  assign w_wr_accept = wr_en_in && !((ZERO_REG != 0) && (wr_addr_in == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // The counter wrap from DEPTH-1 to 0 lines up with the return to IDLE.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    if (r_state == ST_IDLE) begin
      if (clr_in) begin
        w_state_next   = ST_CLEAR;
        w_clr_cnt_next = '0;
      end
    end else begin
      w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
      if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
        w_state_next = ST_IDLE;
      end
    end
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_accept) begin
      r_mem[wr_addr_in] <= wr_data_in;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    localparam int LO_A = slice_lo(gi, ADDR_W);
    localparam int LO_D = slice_lo(gi, DATA_W);

    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .i_mem    (r_mem),
      .i_state  (r_state),
      .i_addr   (rd_addr_in[LO_A +: ADDR_W]),
      .i_wr_en  (wr_en_in),
      .i_wr_addr(wr_addr_in),
      .i_wr_data(wr_data_in),
      .o_data   (rd_data_out[LO_D +: DATA_W])
    );
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised successor of the 32x32 register file for the RISC-V core. It provides a configurable width, depth and number of combinational read ports, with an optional hardwired-zero entry 0 and optional write-to-read bypass. Contents are cleared by an internal sequencer, one entry per cycle, after reset or on command, instead of by a wide asynchronous clear. It sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, data width of each entry
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_in  in  1  single-cycle pulse: start a clear sweep
wr_en_in  in  1  write enable
wr_addr_in  in  ADDR_W  write address
wr_data_in  in  DATA_W  write data
rd_addr_in  in  NUM_RD*ADDR_W  read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data_out  out  NUM_RD*DATA_W  read data; port k = bits [k*DATA_W +: DATA_W]
ready_out  out  1  1 = IDLE; writes accepted, reads valid
busy_out  out  1  1 = clear sweep in progress (always the inverse of ready_out)

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock, and rst_n low immediately forces state CLEAR, clr_cnt = 0, ready_out = 0 and busy_out = 1. The storage array itself is not reset.
- FSM states: IDLE and CLEAR.
  - CLEAR: each clk writes 0 to entry clr_cnt, then clr_cnt increments. When clr_cnt = DEPTH-1 is written, the next state is IDLE. The sweep therefore takes exactly DEPTH cycles after rst_n deasserts, and ready_out rises on the cycle after the last entry is cleared.
  - IDLE: clr_in = 1 leads to CLEAR with clr_cnt = 0 on the next edge.
- clr_in during CLEAR is ignored; the sweep does not restart.
- Writes: in IDLE, when wr_en_in = 1 the entry is updated at the rising edge.
  - wr_en_in during CLEAR is dropped silently. The producer must check ready_out.
  - If clr_in and wr_en_in are both 1 in IDLE, the write is performed and the sweep starts on the next cycle. That entry is cleared later in the sweep.
- ZERO_REG = 1: writes to address 0 are discarded and reads of address 0 return 0.
- Reads are combinational with 0-cycle latency and are evaluated per port independently.
  - While busy_out = 1, all rd_data_out are forced to 0.
  - BYPASS = 1, IDLE, wr_en_in = 1 and rd_addr == wr_addr (and not the zero entry): rd_data = wr_data_in in the same cycle.
  - BYPASS = 0: the old value is returned until the edge.
- Multiple read ports with the same address return identical data.
- Out-of-range address cannot occur, since DEPTH is a power of two. clr_cnt is ADDR_W bits wide and its wrap from DEPTH-1 to 0 coincides with the CLEAR-to-IDLE transition.
- Reset asserted mid-sweep or mid-write aborts it and the sweep restarts from 0.

Decomposition:
- Package regfile_pkg holds:
  - state encoding localparams ST_IDLE = 1'b0 and ST_CLEAR = 1'b1;
  - a helper function for port-slice extraction.
- Sub-module regfile_read_port (instantiated NUM_RD times via generate) contains the array mux, zero-entry gating, bypass compare and busy gating.
- The top level contains the storage, the write logic and the FSM/counter.

Test Plan:
1. Release rst_n with ADDR_W = 5 -> ready_out = 0 for exactly 32 cycles, then 1; read every entry on both ports -> all 0x00000000.
2. IDLE, write 0xDEADBEEF to entry 7, next cycle read port0 = 7 and port1 = 7 -> both 0xDEADBEEF; write 0x12345678 to entry 0 -> reading 0 returns 0.
3. BYPASS = 1: entry 3 holds 0x11; in the same cycle, wr_en_in = 1, addr 3, data 0x22 with port1 = 3 -> port1 = 0x22 combinationally. Rerun with BYPASS = 0 -> 0x11, then 0x22 the next cycle.
4. Fill entries 1..31, pulse clr_in -> busy_out = 1 for 32 cycles and reads = 0. A write to entry 5 during the sweep is dropped, and entry 5 reads 0 afterwards. A second clr_in mid-sweep does not extend it (still 32 cycles).
5. Assert rst_n low during sweep cycle 10 -> ready_out = 0 immediately; after release, the full 32-cycle sweep is repeated and all entries are 0.
6. NUM_RD = 3, DATA_W = 64, ADDR_W = 4: three different addresses return their own 64-bit values in the same cycle, and ready_out rises after 16 cycles.
